// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: drives one shared 4-bit slice LSN first, chaining carry.
// Optional subtract mode enabled by defining SUB_EN (adds in_sub port).
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
`ifdef SUB_EN
    input  logic                   in_sub,
`endif
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy
);

    localparam int unsigned    W    = 4 * NIBBLES;
    localparam int unsigned    NW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NW-1:0]  LAST = NW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, sum_q;
    logic [NW-1:0]   nib_q, nib_d;
    logic            carry_q, cout_q, cin_d;
    logic [3:0]      a_nib, b_nib;
    logic            run;

`ifdef SUB_EN
    logic            sub_q;
    // Subtraction is A + ~B + 1, so the first carry is forced high.
    assign cin_d = in_sub | in_cin;
`else
    assign cin_d = in_cin;
`endif

    assign nib_d = nib_q + NW'(1);
    assign run   = (state_q == RUN);
    assign a_nib = a_q[4*nib_q +: 4];
    assign b_nib = b_q[4*nib_q +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            nib_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= cin_d;
                        nib_q   <= '0;
                        state_q <= RUN;
`ifdef SUB_EN
                        sub_q   <= in_sub;
`endif
                    end
                end
                RUN: begin
                    sum_q[4*nib_q +: 4] <= add_sum;
                    carry_q             <= add_cout;
                    if (nib_q == LAST) begin
                        cout_q  <= add_cout;
                        nib_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        nib_q <= nib_d;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    assign add_a   = run ? a_nib : '0;
    assign add_cin = run & carry_q;
`ifdef SUB_EN
    assign add_b   = run ? (b_nib ^ {4{sub_q}}) : '0;
`else
    assign add_b   = run ? b_nib : '0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: NIBBLES=4 directed vectors plus a NIBBLES=1 exhaustive sweep.
// Subtract vectors run only when SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // NIBBLES = 4 instance
    logic        in_valid4 = 1'b0, in_ready4, in_cin4 = 1'b0;
    logic [15:0] a4 = '0, b4 = '0, out_sum4;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4, out_valid4, out_cout4, busy4;
    logic        out_ready4 = 1'b1;
`ifdef SUB_EN
    logic        sub4 = 1'b0;
`endif

    // NIBBLES = 1 instance
    logic        in_valid1 = 1'b0, in_ready1, in_cin1 = 1'b0;
    logic [3:0]  a1 = '0, b1 = '0, out_sum1;
    logic [3:0]  add_a1, add_b1, add_sum1;
    logic        add_cin1, add_cout1, out_valid1, out_cout1, busy1;
    logic        out_ready1 = 1'b1;
`ifdef SUB_EN
    logic        sub1 = 1'b0;
`endif

    // Reference 4-bit ripple slices
    always_comb begin
        {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};
        {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_cin1};
    end

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(a4), .in_b(b4), .in_cin(in_cin4),
`ifdef SUB_EN
        .in_sub(sub4),
`endif
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(a1), .in_b(b1), .in_cin(in_cin1),
`ifdef SUB_EN
        .in_sub(sub1),
`endif
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
    );

    logic [16:0] exp4_q[$];
    logic [4:0]  exp1_q[$];
    logic        cin_q[$];
    logic        chk_cin = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop expected results / carry sequence whenever the DUT presents them
    always @(negedge clk) begin : mon
        logic [16:0] e4;
        logic [4:0]  e1;
        if (!rst && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) chk("dut4 unexpected result", 32'd1, 32'd0);
            else begin
                e4 = exp4_q.pop_front();
                chk("dut4 result", {15'b0, out_cout4, out_sum4}, {15'b0, e4});
            end
        end
        if (!rst && chk_cin && busy4 && !out_valid4) begin
            if (cin_q.size() == 0) chk("dut4 unexpected RUN cycle", 32'd1, 32'd0);
            else chk("dut4 add_cin sequence", {31'b0, add_cin4}, {31'b0, cin_q.pop_front()});
        end
        if (!rst && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) chk("dut1 unexpected result", 32'd1, 32'd0);
            else begin
                e1 = exp1_q.pop_front();
                chk("dut1 result", {27'b0, out_cout1, out_sum1}, {27'b0, e1});
            end
        end
    end

    task automatic offer4(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
`ifdef SUB_EN
        sub4 = sub;
`endif
        n = 0;
        while (!in_ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: a=%h b=%h sub=%0b in_ready got 0 expected 1", a, b, sub);
        end
        @(posedge clk);
        #1 in_valid4 = 1'b0;
    endtask

    task automatic wait_valid4();
        int lat;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("dut4 latency", lat, 32'd4);
    endtask

    // cins bit k = expected add_cin during nibble k
    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic [3:0] cins);
        exp4_q.push_back({ec, es});
        for (int k = 0; k < 4; k++) cin_q.push_back(cins[k]);
        offer4(a, b, cin, sub);
        wait_valid4();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n, prev;
        logic seen;
        logic [4:0] e;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'b0, in_ready4}, 32'd0);
        chk("reset outputs", {out_valid4, busy4, out_cout4, out_sum4, add_a4, add_b4, add_cin4}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("in_ready after reset", {30'b0, in_ready4, in_ready1}, 32'd3);

        send4(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 4'b0000);
        send4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 4'b1110);
        send4(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 4'b1111);
        send4(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 4'b0001);

        // Abort mid-RUN: nothing queued, no result must appear
        chk_cin = 1'b0;
        offer4(16'hABCD, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("busy before abort", {31'b0, busy4}, 32'd1);
        @(negedge clk) rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("in_ready during reset", {31'b0, in_ready4}, 32'd0);
            chk("outputs during reset", {out_valid4, busy4, out_cout4, out_sum4, add_a4, add_b4, add_cin4}, 32'd0);
        end
        @(negedge clk) rst = 1'b0;
        #1 chk("in_ready after release", {31'b0, in_ready4}, 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid4) seen = 1'b1;
        end
        chk("no result for aborted op", {31'b0, seen}, 32'd0);
        chk_cin = 1'b1;

        // Backpressure with a second pair waiting
        out_ready4 = 1'b0;
        send4(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 4'b0000);
        @(negedge clk);
        a4 = 16'h0F0F; b4 = 16'h0101; in_cin4 = 1'b0; in_valid4 = 1'b1;
        exp4_q.push_back({1'b0, 16'h1010});
        cin_q.push_back(1'b0); cin_q.push_back(1'b1); cin_q.push_back(1'b0); cin_q.push_back(1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("stall out_sum", {16'b0, out_sum4}, 32'h3333);
            chk("stall flags", {29'b0, out_cout4, in_ready4, out_valid4}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready4 = 1'b1;
        @(posedge clk);
        #1 chk("idle after result handshake", {30'b0, busy4, in_ready4}, 32'd1);
        @(posedge clk);
        #1 chk("accept at F+1", {31'b0, busy4}, 32'd1);
        in_valid4 = 1'b0;
        wait_valid4();

`ifdef SUB_EN
        send4(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 4'b0001);
        send4(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 4'b1111);
`endif

        // NIBBLES = 1 back-to-back sweep
        in_valid1 = 1'b1;
        prev = 0;
        for (int i = 0; i < 512; i++) begin
            a1 = i[3:0]; b1 = i[7:4]; in_cin1 = i[8];
            e = {1'b0, a1} + {1'b0, b1} + {4'b0, in_cin1};
            exp1_q.push_back(e);
            n = 0;
            @(negedge clk);
            while (!in_ready1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (n >= 10) chk("dut1 accept timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            if (i > 0) chk("dut1 accept spacing", cyc - prev, 32'd3);
            prev = cyc;
        end
        in_valid1 = 1'b0;

        n = 0;
        while ((exp4_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("dut4 results drained", exp4_q.size(), 32'd0);
        chk("dut1 results drained", exp1_q.size(), 32'd0);
        chk("carry sequence drained", cin_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
